// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage between the Branch/ALU and Memory pipes and the
// dual-write-port register file.
//
// Each pipe pushes results into its own small FIFO (DEPTH entries). On every
// rising edge without wb_stall, each non-empty lane pops its head into a
// registered RF write command. The register file samples these outputs on the
// falling edge. When both lanes pop writes to the same nonzero register, only
// the younger one (larger PC) keeps its write enable. The RF therefore never
// sees two enabled writes to one register. On a PC tie the Memory lane wins.
//
// Ports:
//   clk, rst                       clock (rising edge) and async active-low reset
//   br_valid/ready/rd/wd/pc/we     Branch-lane producer handshake and payload
//   mem_valid/ready/rd/wd/pc/we    Memory-lane producer handshake and payload
//   wb_stall                       freezes draining; FIFOs still accept
//   rd/wd/PC_out/write_en_Branch   registered RF Branch-port write command
//   rd/wd/PC_out/write_en_Memory   registered RF Memory-port write command
//   pending                        total entries held in both FIFOs
module wb_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RS    = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic                        br_valid,
  output logic                        br_ready,
  input  logic [RS-1:0]               br_rd,
  input  logic [WIDTH-1:0]            br_wd,
  input  logic [WIDTH-1:0]            br_pc,
  input  logic                        br_we,

  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic [RS-1:0]               mem_rd,
  input  logic [WIDTH-1:0]            mem_wd,
  input  logic [WIDTH-1:0]            mem_pc,
  input  logic                        mem_we,

  input  logic                        wb_stall,

  output logic [RS-1:0]               rd_Branch,
  output logic [WIDTH-1:0]            wd_Branch,
  output logic [WIDTH-1:0]            PC_out_Branch,
  output logic                        write_en_Branch,

  output logic [RS-1:0]               rd_Memory,
  output logic [WIDTH-1:0]            wd_Memory,
  output logic [WIDTH-1:0]            PC_out_Memory,
  output logic                        write_en_Memory,

  output logic [$clog2(2*DEPTH):0]    pending
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;
  localparam int unsigned PendW = $clog2(2 * DEPTH) + 1;

  typedef struct packed {
    logic [RS-1:0]    rd;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] pc;
    logic             we;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Branch lane FIFO
  // ---------------------------------------------------------------------------
  entry_t            br_mem_q [DEPTH];
  logic [PtrW-1:0]   br_wptr_q, br_rptr_q;
  logic [CntW-1:0]   br_cnt_q, br_cnt_d;
  logic              br_full, br_empty, br_push, br_pop;
  entry_t            br_in, br_head;

  assign br_in    = '{rd: br_rd, wd: br_wd, pc: br_pc, we: br_we};
  assign br_full  = (br_cnt_q == CntW'(DEPTH));
  assign br_empty = (br_cnt_q == '0);
  // No same-cycle pop credit: a full lane refuses even if it drains this edge.
  assign br_ready = !br_full;
  assign br_push  = br_valid && br_ready;
  assign br_pop   = !wb_stall && !br_empty;
  assign br_head  = br_mem_q[br_rptr_q];

  always_comb begin
    br_cnt_d = br_cnt_q;
    case ({br_push, br_pop})
      2'b10:   br_cnt_d = br_cnt_q + CntW'(1);
      2'b01:   br_cnt_d = br_cnt_q - CntW'(1);
      default: br_cnt_d = br_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_wptr_q <= '0;
      br_rptr_q <= '0;
      br_cnt_q  <= '0;
    end else begin
      if (br_push) br_wptr_q <= br_wptr_q + PtrW'(1);
      if (br_pop)  br_rptr_q <= br_rptr_q + PtrW'(1);
      br_cnt_q <= br_cnt_d;
    end
  end

  // Storage is not reset; the cleared count marks every slot invalid.
  always_ff @(posedge clk) begin
    if (br_push) br_mem_q[br_wptr_q] <= br_in;
  end

  // ---------------------------------------------------------------------------
  // Memory lane FIFO
  // ---------------------------------------------------------------------------
  entry_t            mem_mem_q [DEPTH];
  logic [PtrW-1:0]   mem_wptr_q, mem_rptr_q;
  logic [CntW-1:0]   mem_cnt_q, mem_cnt_d;
  logic              mem_full, mem_empty, mem_push, mem_pop;
  entry_t            mem_in, mem_head;

  assign mem_in    = '{rd: mem_rd, wd: mem_wd, pc: mem_pc, we: mem_we};
  assign mem_full  = (mem_cnt_q == CntW'(DEPTH));
  assign mem_empty = (mem_cnt_q == '0);
  assign mem_ready = !mem_full;
  assign mem_push  = mem_valid && mem_ready;
  assign mem_pop   = !wb_stall && !mem_empty;
  assign mem_head  = mem_mem_q[mem_rptr_q];

  always_comb begin
    mem_cnt_d = mem_cnt_q;
    case ({mem_push, mem_pop})
      2'b10:   mem_cnt_d = mem_cnt_q + CntW'(1);
      2'b01:   mem_cnt_d = mem_cnt_q - CntW'(1);
      default: mem_cnt_d = mem_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_wptr_q <= '0;
      mem_rptr_q <= '0;
      mem_cnt_q  <= '0;
    end else begin
      if (mem_push) mem_wptr_q <= mem_wptr_q + PtrW'(1);
      if (mem_pop)  mem_rptr_q <= mem_rptr_q + PtrW'(1);
      mem_cnt_q <= mem_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_push) mem_mem_q[mem_wptr_q] <= mem_in;
  end

  assign pending = PendW'(br_cnt_q) + PendW'(mem_cnt_q);

  // ---------------------------------------------------------------------------
  // Conflict resolution between simultaneously popped heads
  // ---------------------------------------------------------------------------
  logic same_dst;
  logic br_wen, mem_wen;

  assign same_dst = br_pop && mem_pop && br_head.we && mem_head.we &&
                    (br_head.rd != '0) && (br_head.rd == mem_head.rd);

  // The older write (smaller PC) is dead. On a tie, the Branch lane yields.
  assign br_wen  = br_head.we && (br_head.rd != '0) &&
                   !(same_dst && (br_head.pc <= mem_head.pc));
  assign mem_wen = mem_head.we && (mem_head.rd != '0) &&
                   !(same_dst && (mem_head.pc < br_head.pc));

  // ---------------------------------------------------------------------------
  // Registered RF write commands
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_Branch       <= '0;
      wd_Branch       <= '0;
      PC_out_Branch   <= '0;
      write_en_Branch <= 1'b0;
    end else if (br_pop) begin
      rd_Branch       <= br_head.rd;
      wd_Branch       <= br_head.wd;
      PC_out_Branch   <= br_head.pc;
      write_en_Branch <= br_wen;
    end else begin
      // Empty lane or stall: only the enable drops; data holds.
      write_en_Branch <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_Memory       <= '0;
      wd_Memory       <= '0;
      PC_out_Memory   <= '0;
      write_en_Memory <= 1'b0;
    end else if (mem_pop) begin
      rd_Memory       <= mem_head.rd;
      wd_Memory       <= mem_head.wd;
      PC_out_Memory   <= mem_head.pc;
      write_en_Memory <= mem_wen;
    end else begin
      write_en_Memory <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        br_valid, br_ready, br_we;
  logic [4:0]  br_rd;
  logic [31:0] br_wd, br_pc;
  logic        mem_valid, mem_ready, mem_we;
  logic [4:0]  mem_rd;
  logic [31:0] mem_wd, mem_pc;
  logic        wb_stall;
  logic [4:0]  rd_Branch, rd_Memory;
  logic [31:0] wd_Branch, PC_out_Branch, wd_Memory, PC_out_Memory;
  logic        write_en_Branch, write_en_Memory;
  logic [2:0]  pending;

  int checks;
  int failures;

  wb_arbiter #(
    .WIDTH(32),
    .RS(5),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .br_valid(br_valid),
    .br_ready(br_ready),
    .br_rd(br_rd),
    .br_wd(br_wd),
    .br_pc(br_pc),
    .br_we(br_we),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_rd(mem_rd),
    .mem_wd(mem_wd),
    .mem_pc(mem_pc),
    .mem_we(mem_we),
    .wb_stall(wb_stall),
    .rd_Branch(rd_Branch),
    .wd_Branch(wd_Branch),
    .PC_out_Branch(PC_out_Branch),
    .write_en_Branch(write_en_Branch),
    .rd_Memory(rd_Memory),
    .wd_Memory(wd_Memory),
    .PC_out_Memory(PC_out_Memory),
    .write_en_Memory(write_en_Memory),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        bv;
    logic [4:0]  brd;
    logic [31:0] bwd;
    logic [31:0] bpc;
    logic        bwe;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mwd;
    logic [31:0] mpc;
    logic        mwe;
    logic        ewb;
    logic        ewm;
  } vec_t;

  localparam int NumVec = 10;
  vec_t vecs [NumVec];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    br_valid = 1'b0; br_rd = '0; br_wd = '0; br_pc = '0; br_we = 1'b0;
    mem_valid = 1'b0; mem_rd = '0; mem_wd = '0; mem_pc = '0; mem_we = 1'b0;
    wb_stall = 1'b0;

    //         bv    brd    bwd            bpc            bwe   mv    mrd    mwd            mpc            mwe   ewb   ewm
    vecs[0] = '{1'b1, 5'd5, 32'hAAAA_0001, 32'h0000_0000, 1'b1, 1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 5'd7, 32'h0000_0001, 32'h0000_0100, 1'b1, 1'b1, 5'd7, 32'h0000_0002, 32'h0000_0104, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 5'd7, 32'h0000_0001, 32'h0000_0104, 1'b1, 1'b1, 5'd7, 32'h0000_0002, 32'h0000_0100, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 5'd9, 32'h0000_0011, 32'h0000_0200, 1'b1, 1'b1, 5'd9, 32'h0000_0022, 32'h0000_0200, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h0000_0300, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 5'd3, 32'h0000_0033, 32'h0000_0310, 1'b0, 1'b0, 5'd0, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 5'd4, 32'h0000_0044, 32'h0000_0400, 1'b1, 1'b1, 5'd6, 32'h0000_0066, 32'h0000_0404, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 5'd7, 32'h0000_0077, 32'h0000_0500, 1'b0, 1'b1, 5'd7, 32'h0000_0078, 32'h0000_0400, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 5'd0, 32'h0000_0001, 32'h0000_0600, 1'b1, 1'b1, 5'd0, 32'h0000_0002, 32'h0000_0604, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 5'd8, 32'h0000_0088, 32'h0000_0010, 1'b1, 1'b1, 5'd8, 32'h0000_0089, 32'h0000_0020, 1'b0, 1'b1, 1'b0};

    // Reset state
    #1;
    check("rst wen_b", {31'd0, write_en_Branch}, 32'd0);
    check("rst wen_m", {31'd0, write_en_Memory}, 32'd0);
    check("rst pending", {29'd0, pending}, 32'd0);
    check("rst rd_b", {27'd0, rd_Branch}, 32'd0);
    check("rst wd_m", wd_Memory, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("post-rst br_ready", {31'd0, br_ready}, 32'd1);
    check("post-rst mem_ready", {31'd0, mem_ready}, 32'd1);

    // Table-driven single-transaction vectors
    for (int i = 0; i < NumVec; i++) begin
      br_valid  = vecs[i].bv;  br_rd  = vecs[i].brd; br_wd  = vecs[i].bwd;
      br_pc     = vecs[i].bpc; br_we  = vecs[i].bwe;
      mem_valid = vecs[i].mv;  mem_rd = vecs[i].mrd; mem_wd = vecs[i].mwd;
      mem_pc    = vecs[i].mpc; mem_we = vecs[i].mwe;
      step();  // accept edge
      check($sformatf("v%0d nobypass wen_b", i), {31'd0, write_en_Branch}, 32'd0);
      check($sformatf("v%0d nobypass wen_m", i), {31'd0, write_en_Memory}, 32'd0);
      check($sformatf("v%0d pending", i), {29'd0, pending},
            32'(vecs[i].bv) + 32'(vecs[i].mv));
      br_valid  = 1'b0;
      mem_valid = 1'b0;
      step();  // drain edge
      check($sformatf("v%0d wen_b", i), {31'd0, write_en_Branch}, {31'd0, vecs[i].ewb});
      check($sformatf("v%0d wen_m", i), {31'd0, write_en_Memory}, {31'd0, vecs[i].ewm});
      if (vecs[i].bv) begin
        check($sformatf("v%0d rd_b", i), {27'd0, rd_Branch}, {27'd0, vecs[i].brd});
        check($sformatf("v%0d wd_b", i), wd_Branch, vecs[i].bwd);
        check($sformatf("v%0d pc_b", i), PC_out_Branch, vecs[i].bpc);
      end
      if (vecs[i].mv) begin
        check($sformatf("v%0d rd_m", i), {27'd0, rd_Memory}, {27'd0, vecs[i].mrd});
        check($sformatf("v%0d wd_m", i), wd_Memory, vecs[i].mwd);
        check($sformatf("v%0d pc_m", i), PC_out_Memory, vecs[i].mpc);
      end
      check($sformatf("v%0d drained", i), {29'd0, pending}, 32'd0);
      step();  // idle edge: enables fall back to 0
      check($sformatf("v%0d idle wen_b", i), {31'd0, write_en_Branch}, 32'd0);
      check($sformatf("v%0d idle wen_m", i), {31'd0, write_en_Memory}, 32'd0);
    end

    // Backpressure: stall and fill the Memory lane, the third push must be held
    wb_stall  = 1'b1;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_pc = 32'h1000; mem_we = 1'b1; mem_wd = 32'd1;
    step();
    check("bp ready after 1", {31'd0, mem_ready}, 32'd1);
    check("bp pending 1", {29'd0, pending}, 32'd1);
    mem_wd = 32'd2; mem_pc = 32'h1004;
    step();
    check("bp ready after 2", {31'd0, mem_ready}, 32'd0);
    check("bp pending 2", {29'd0, pending}, 32'd2);
    check("bp stall wen_m", {31'd0, write_en_Memory}, 32'd0);
    mem_wd = 32'd3; mem_pc = 32'h1008;
    step();
    check("bp held pending", {29'd0, pending}, 32'd2);
    check("bp held wen_m", {31'd0, write_en_Memory}, 32'd0);
    wb_stall = 1'b0;
    step();  // pop 1; lane was full so 3 not accepted yet
    check("bp out1 wen", {31'd0, write_en_Memory}, 32'd1);
    check("bp out1 wd", wd_Memory, 32'd1);
    check("bp out1 pending", {29'd0, pending}, 32'd1);
    step();  // pop 2, accept 3
    mem_valid = 1'b0;
    check("bp out2 wen", {31'd0, write_en_Memory}, 32'd1);
    check("bp out2 wd", wd_Memory, 32'd2);
    check("bp out2 pending", {29'd0, pending}, 32'd1);
    step();
    check("bp out3 wen", {31'd0, write_en_Memory}, 32'd1);
    check("bp out3 wd", wd_Memory, 32'd3);
    check("bp out3 pc", PC_out_Memory, 32'h1008);
    check("bp empty pending", {29'd0, pending}, 32'd0);
    step();
    check("bp idle wen_m", {31'd0, write_en_Memory}, 32'd0);

    // Stall drops an enable that was high on the previous edge
    br_valid = 1'b1; br_rd = 5'd12; br_wd = 32'h1234; br_pc = 32'h2000; br_we = 1'b1;
    step();
    br_wd = 32'h5678; br_pc = 32'h2004;
    step();  // pop first, accept second
    br_valid = 1'b0;
    check("st wen before", {31'd0, write_en_Branch}, 32'd1);
    wb_stall = 1'b1;
    step();
    check("st wen forced 0", {31'd0, write_en_Branch}, 32'd0);
    check("st data held", wd_Branch, 32'h1234);
    check("st pending held", {29'd0, pending}, 32'd1);
    wb_stall = 1'b0;
    step();
    check("st resume wd", wd_Branch, 32'h5678);
    check("st resume wen", {31'd0, write_en_Branch}, 32'd1);
    step();

    // Reset mid-flight
    br_valid = 1'b1; br_rd = 5'd1; br_wd = 32'hB1; br_pc = 32'h3000; br_we = 1'b1;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_wd = 32'hA1; mem_pc = 32'h3004; mem_we = 1'b1;
    step();
    br_wd = 32'hB2; mem_wd = 32'hA2;
    step();
    br_valid = 1'b0; mem_valid = 1'b0;
    check("mr pre wen_b", {31'd0, write_en_Branch}, 32'd1);
    check("mr pre pending", {29'd0, pending}, 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check("mr async wen_b", {31'd0, write_en_Branch}, 32'd0);
    check("mr async wen_m", {31'd0, write_en_Memory}, 32'd0);
    check("mr async pending", {29'd0, pending}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    check("mr after wen_b", {31'd0, write_en_Branch}, 32'd0);
    check("mr after wen_m", {31'd0, write_en_Memory}, 32'd0);
    step();
    check("mr after2 wen_b", {31'd0, write_en_Branch}, 32'd0);
    check("mr after2 pending", {29'd0, pending}, 32'd0);

    // Pointer wrap: 2*DEPTH+1 back-to-back Branch pushes, no stall
    br_rd = 5'd20; br_we = 1'b1;
    for (int i = 0; i < 5; i++) begin
      br_valid = 1'b1;
      br_wd    = 32'h100 + 32'(i);
      br_pc    = 32'h4000 + 32'(4 * i);
      check($sformatf("wrap%0d ready", i), {31'd0, br_ready}, 32'd1);
      step();
      if (i == 0) begin
        check("wrap0 wen", {31'd0, write_en_Branch}, 32'd0);
      end else begin
        check($sformatf("wrap%0d wen", i), {31'd0, write_en_Branch}, 32'd1);
        check($sformatf("wrap%0d wd", i), wd_Branch, 32'h100 + 32'(i - 1));
      end
      check($sformatf("wrap%0d pending", i), {29'd0, pending}, 32'd1);
    end
    br_valid = 1'b0;
    step();
    check("wrap last wen", {31'd0, write_en_Branch}, 32'd1);
    check("wrap last wd", wd_Branch, 32'h104);
    check("wrap last pending", {29'd0, pending}, 32'd0);
    step();
    check("wrap idle wen", {31'd0, write_en_Branch}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
